rr_mux_arbiter_4: RTL and testbench

Round-robin arbiter that shares one 4:1 datapath mux between four valid/ready requesters and drives a single registered output stream. Each requester sends beats of `W`-bit data with a `last` flag. A grant holds for a whole packet, up to and including the beat with `last` set. The block sits in front of any single-consumer sink that must be fed from four sources, and replaces a free-running `sel` with sequenced, fair selection.

---
 rtl/rr_mux_arbiter_4.sv | 130 +++++++++++++
 tb/tb_rr_mux_arbiter_4.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter_4.sv
// Round-robin arbiter sharing one 4:1 mux among four valid/ready
// packet sources, feeding a single registered output stream.
module rr_mux_arbiter_4 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   in_valid,
  input  logic [3:0]   in_last,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic [3:0]   in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic [1:0]   out_sel,
  input  logic         out_ready,
  output logic         busy
);

  typedef enum logic {
    IDLE,
    LOCK
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [1:0]   r_ptr;
  logic [1:0]   r_lock;
  logic         r_out_valid;
  logic [W-1:0] r_out_data;
  logic         r_out_last;
  logic [1:0]   r_out_sel;

  logic         w_load;
  logic         w_found;
  logic [1:0]   w_win;
  logic [1:0]   w_idx;
  logic         w_xfer;
  logic         w_last;
  logic [W-1:0] w_data;

  assign w_load = !r_out_valid || out_ready;

  // first valid requester after the last winner, wrapping mod 4
  always_comb begin
    w_found = 1'b0;
    w_win   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      if (!w_found && in_valid[r_ptr + 2'(k)]) begin
        w_found = 1'b1;
        w_win   = r_ptr + 2'(k);
      end
    end
  end

  assign w_idx = (r_state == LOCK) ? r_lock : w_win;

  always_comb begin
    in_ready = 4'b0000;
    if (rst_n) begin
      if (r_state == LOCK)
        in_ready[r_lock] = w_load;
      else if (w_load && w_found)
        in_ready[w_win] = 1'b1;
    end
  end

  assign w_xfer = in_valid[w_idx] && in_ready[w_idx];
  assign w_last = in_last[w_idx];

  always_comb begin
    w_data = d0;
    unique case (w_idx)
      2'd0: w_data = d0;
      2'd1: w_data = d1;
      2'd2: w_data = d2;
      2'd3: w_data = d3;
      default: w_data = d0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (w_xfer && !w_last) w_state_nxt = LOCK;
      LOCK: if (w_xfer && w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= 2'd3;
      r_lock  <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_xfer) begin
        r_ptr  <= w_win;
        r_lock <= w_win;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_sel   <= 2'd0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_data;
      r_out_last  <= w_last;
      r_out_sel   <= w_idx;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_sel   = r_out_sel;
  assign busy      = (r_state == LOCK);

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// Directed bench for rr_mux_arbiter_4.
module tb_rr_mux_arbiter_4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_valid;
  logic [3:0] in_last;
  logic [3:0] d0, d1, d2, d3;
  logic [3:0] in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_last;
  logic [1:0] out_sel;
  logic       out_ready;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  rr_mux_arbiter_4 #(.W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_last(in_last),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_sel(out_sel),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v,
                         input logic [3:0] d, input logic l,
                         input logic [1:0] s, input logic b);
    chk({tag, ".valid"}, 8'(out_valid), 8'(v));
    chk({tag, ".data"}, 8'(out_data), 8'(d));
    chk({tag, ".last"}, 8'(out_last), 8'(l));
    chk({tag, ".sel"}, 8'(out_sel), 8'(s));
    chk({tag, ".busy"}, 8'(busy), 8'(b));
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 4'b1111;
    in_last = 4'b1111;
    d0 = 4'd1; d1 = 4'd2; d2 = 4'd3; d3 = 4'd4;
    out_ready = 1'b1;

    // reset with every port requesting
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_out("rst", 1'b0, 4'd0, 1'b0, 2'd0, 1'b0);
      chk("rst.ready", 8'(in_ready), 8'h0);
    end

    // fairness: 0,1,2,3,0,1
    rst_n = 1'b1;
    #1;
    chk("fair0.ready", 8'(in_ready), 8'b0001);
    tick();
    chk_out("fair0", 1'b1, 4'd1, 1'b1, 2'd0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      chk("fair.ready", 8'(in_ready), 8'(4'b0001 << (i % 4)));
      tick();
      chk_out("fair", 1'b1, 4'((i % 4) + 1), 1'b1, 2'(i % 4), 1'b0);
    end

    // packet lock on port 2 while port 1 waits
    in_valid = 4'b0110;
    in_last = 4'b0010;
    d1 = 4'd8; d2 = 4'd5;
    #1;
    chk("lock.ready0", 8'(in_ready), 8'b0100);
    tick();
    chk_out("lock5", 1'b1, 4'd5, 1'b0, 2'd2, 1'b1);
    d2 = 4'd6;
    #1;
    chk("lock.ready1", 8'(in_ready), 8'b0100);
    tick();
    chk_out("lock6", 1'b1, 4'd6, 1'b0, 2'd2, 1'b1);
    d2 = 4'd7;
    in_last = 4'b0110;
    tick();
    chk_out("lock7", 1'b1, 4'd7, 1'b1, 2'd2, 1'b0);
    in_valid = 4'b0010;
    #1;
    chk("lock.next_ready", 8'(in_ready), 8'b0010);
    tick();
    chk_out("lock.p1", 1'b1, 4'd8, 1'b1, 2'd1, 1'b0);

    // bubble inside a port-3 packet with port 0 waiting
    in_valid = 4'b1001;
    in_last = 4'b0000;
    d0 = 4'd1; d3 = 4'hA;
    tick();
    chk_out("bub.first", 1'b1, 4'hA, 1'b0, 2'd3, 1'b1);
    in_valid = 4'b0001;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("bub.ready", 8'(in_ready), 8'b1000);
      tick();
      chk_out("bub.hole", 1'b0, 4'hA, 1'b0, 2'd3, 1'b1);
    end
    in_valid = 4'b1001;
    in_last = 4'b1000;
    d3 = 4'hB;
    tick();
    chk_out("bub.resume", 1'b1, 4'hB, 1'b1, 2'd3, 1'b0);

    // backpressure holding a beat of 9
    in_valid = 4'b0001;
    in_last = 4'b1111;
    d0 = 4'd9;
    tick();
    chk_out("bp.load", 1'b1, 4'd9, 1'b1, 2'd0, 1'b0);
    out_ready = 1'b0;
    in_valid = 4'b0010;
    d1 = 4'd3;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp.ready", 8'(in_ready), 8'h0);
      tick();
      chk_out("bp.hold", 1'b1, 4'd9, 1'b1, 2'd0, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release_ready", 8'(in_ready), 8'b0010);
    tick();
    chk_out("bp.next", 1'b1, 4'd3, 1'b1, 2'd1, 1'b0);

    // reset in the middle of a port-1 packet
    in_last = 4'b0000;
    d1 = 4'd4;
    tick();
    chk_out("mrst.start", 1'b1, 4'd4, 1'b0, 2'd1, 1'b1);
    rst_n = 1'b0;
    tick();
    chk_out("mrst.in", 1'b0, 4'd0, 1'b0, 2'd0, 1'b0);
    rst_n = 1'b1;
    in_valid = 4'b0011;
    in_last = 4'b0011;
    d0 = 4'd6;
    #1;
    chk("mrst.ready", 8'(in_ready), 8'b0001);
    tick();
    chk_out("mrst.after", 1'b1, 4'd6, 1'b1, 2'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
